// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of a 128-bit state per clock
// through shared combinational inverse S-box logic, with valid/ready on both sides.
// Optional macro SUB_BYTES_FWD_EN adds a fwdMode input that selects the forward
// S-box for the operation, so the encrypt path can share the unit.
module inv_sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] inputData,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] outputData,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
`ifdef SUB_BYTES_FWD_EN
  ,
  input  logic         fwdMode
`endif
);

  localparam int unsigned NCHUNK = 16 / LANES;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  // Reject lane counts that do not evenly tile the 16-byte state
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("inv_sub_bytes_iter: LANES=%0d is illegal (use 1, 2, 4, 8 or 16)", LANES);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    x2   = gf_mul(x, x);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Inverse affine transform applied ahead of the field inversion
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

`ifdef SUB_BYTES_FWD_EN
  // Forward affine transform applied after the field inversion
  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic fwd);
    return fwd ? fwd_affine(gf_inv(b)) : gf_inv(inv_affine(b));
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return gf_inv(inv_affine(b));
  endfunction
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [127:0]     work, work_nxt;
  logic             accept;
`ifdef SUB_BYTES_FWD_EN
  logic             mode_q, mode_nxt;
`endif

  assign outputData = work;

  // State, chunk counter, working register and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SUB_BYTES_FWD_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      work      <= work_nxt;
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
`ifdef SUB_BYTES_FWD_EN
      mode_q    <= mode_nxt;
`endif
    end
  end

  // Next-state, chunk substitution and in_ready (combinational from out_ready in DONE)
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    in_ready  = 1'b0;
    accept    = 1'b0;
`ifdef SUB_BYTES_FWD_EN
    mode_nxt  = mode_q;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
`ifdef SUB_BYTES_FWD_EN
          work_nxt[8*(15 - (32'(cnt)*LANES + l)) +: 8] =
            sub_byte(work[8*(15 - (32'(cnt)*LANES + l)) +: 8], mode_q);
`else
          work_nxt[8*(15 - (32'(cnt)*LANES + l)) +: 8] =
            sub_byte(work[8*(15 - (32'(cnt)*LANES + l)) +: 8]);
`endif
        end
        if (cnt == LAST_CHUNK) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      work_nxt  = inputData;
      cnt_nxt   = '0;
      state_nxt = BUSY;
`ifdef SUB_BYTES_FWD_EN
      mode_nxt  = fwdMode;
`endif
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: three instances (LANES 4, 1, 16) checked with a
// vector table, handshake/reset corner sequences and randomized traffic against
// a table-built S-box reference.
module tb_inv_sub_bytes_iter;

  localparam int unsigned NDUT = 3;
  localparam int unsigned LV [NDUT] = '{4, 1, 16};

  logic         clk;
  logic         rst_n;
  logic [127:0] din  [NDUT];
  logic [127:0] dout [NDUT];
  logic         iv   [NDUT];
  logic         ir   [NDUT];
  logic         ov   [NDUT];
  logic         ordy [NDUT];
  logic         bsy  [NDUT];
  logic         fm   [NDUT];

  int n_chk;
  int n_fail;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(LV[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inputData (din[g]),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .outputData(dout[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .busy      (bsy[g])
`ifdef SUB_BYTES_FWD_EN
      ,
      .fwdMode   (fm[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned prod;
    prod = 0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (32'h11b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Forward S-box by brute-force inversion, then the inverse table by lookup reversal
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = inv_tab[d[8*(15-i) +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction on DUT k; called #1 after a rising edge with the DUT idle
  task automatic run_one(input int k, input logic [127:0] data, input logic [127:0] exp,
                         input string tag);
    int lat;
    din[k]  = data;
    iv[k]   = 1'b1;
    ordy[k] = 1'b0;
    #1;
    chk($sformatf("%s_in_ready[%0d]", tag, k), 128'(ir[k]), 128'(1));
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s_latency[%0d]", tag, k), 128'(lat), 128'(16 / LV[k]));
    chk($sformatf("%s_data[%0d]", tag, k), dout[k], exp);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk($sformatf("%s_ovalid_drop[%0d]", tag, k), 128'(ov[k]), 128'(0));
    chk($sformatf("%s_busy_drop[%0d]", tag, k), 128'(bsy[k]), 128'(0));
  endtask

  // Random traffic with random input gaps and output stalls; in-order scoreboard
  task automatic rand_run(input int k, input int nvec);
    logic [127:0] q[$];
    logic [127:0] cur;
    logic [127:0] e;
    logic         have;
    int sent, got, cyc;
    have = 1'b0; sent = 0; got = 0; cyc = 0; cur = '0;
    while (got < nvec && cyc < 40000) begin
      if (!have && sent < nvec && $urandom_range(0, 3) != 0) begin
        cur  = {$urandom, $urandom, $urandom, $urandom};
        have = 1'b1;
      end
      iv[k]   = have;
      din[k]  = cur;
      ordy[k] = ($urandom_range(0, 2) != 0);
      #1;
      if (iv[k] && ir[k]) begin
        q.push_back(ref_inv(cur));
        sent++;
        have = 1'b0;
      end
      if (ov[k] && ordy[k]) begin
        e = (q.size() > 0) ? q.pop_front() : 128'hx;
        chk($sformatf("rand_data[%0d] #%0d", k, got), dout[k], e);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b0;
    chk($sformatf("rand_count_out[%0d]", k), 128'(got), 128'(nvec));
    chk($sformatf("rand_count_in[%0d]", k), 128'(sent), 128'(got));
    chk($sformatf("rand_queue_empty[%0d]", k), 128'(q.size()), 128'(0));
  endtask

  initial begin
    vec_t vt [3];
    logic [127:0] va, vb, ea, eb;
    int lat;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      din[k] = '0; iv[k] = 1'b0; ordy[k] = 1'b0; fm[k] = 1'b0;
    end
    build_tables();

    vt[0] = '{din: 128'h637c777bf26b6fc53001672bfed7ab76, exp: 128'h000102030405060708090a0b0c0d0e0f};
    vt[1] = '{din: {16{8'h00}}, exp: {16{8'h52}}};
    vt[2] = '{din: {16{8'h16}}, exp: {16{8'hff}}};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), 128'(ov[k]), 128'(0));
      chk($sformatf("rst_busy[%0d]", k), 128'(bsy[k]), 128'(0));
      chk($sformatf("rst_outputData[%0d]", k), dout[k], 128'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("post_rst_in_ready[%0d]", k), 128'(ir[k]), 128'(1));

    // Table vectors on every lane configuration
    for (int k = 0; k < NDUT; k++)
      for (int v = 0; v < 3; v++)
        run_one(k, vt[v].din, vt[v].exp, $sformatf("vec%0d", v));

    // Stall in DONE, then same-cycle release and accept
    va = vt[0].din; ea = vt[0].exp;
    vb = {$urandom, $urandom, $urandom, $urandom};
    eb = ref_inv(vb);
    din[0] = va; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("hold_latency", 128'(lat), 128'(4));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold_ovalid c%0d", c), 128'(ov[0]), 128'(1));
      chk($sformatf("hold_data c%0d", c), dout[0], ea);
      chk($sformatf("hold_in_ready c%0d", c), 128'(ir[0]), 128'(0));
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1; iv[0] = 1'b1; din[0] = vb;
    #1;
    chk("b2b_in_ready", 128'(ir[0]), 128'(1));
    chk("b2b_first_data", dout[0], ea);
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b0;
    chk("b2b_ovalid_drop", 128'(ov[0]), 128'(0));
    chk("b2b_busy", 128'(bsy[0]), 128'(1));
    lat = 0;
    while (!ov[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_latency", 128'(lat), 128'(4));
    chk("b2b_second_data", dout[0], eb);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("b2b_no_dup", 128'(ov[0]), 128'(0));

    // Asynchronous reset during the second BUSY cycle
    din[0] = vb; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_before", 128'(bsy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(ov[0]), 128'(0));
    chk("midrst_busy", 128'(bsy[0]), 128'(0));
    chk("midrst_outputData", dout[0], 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_output", 128'(ov[0]), 128'(0));
    run_one(0, va, ea, "after_rst");

`ifdef SUB_BYTES_FWD_EN
    fm[0] = 1'b1;
    run_one(0, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, "fwd");
    fm[0] = 1'b0;
    run_one(0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, "fwd_back");
`endif

    rand_run(0, 1000);
    rand_run(1, 150);
    rand_run(2, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
